// File: rtl/img_block_transpose_buf_if.sv
// Sample-stream bundle for the block transpose buffer: input stream, per-block mode and output stream.
// The producer/consumer side takes the master modport; the buffer takes the slave modport.
interface img_block_transpose_buf_if #(
  parameter int unsigned DATA_W = 16
);
  logic              mode;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_first;
  logic              out_last;

  modport master (
    output mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_first, out_last
  );

  modport slave (
    input  mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_first, out_last
  );
endinterface

// File: rtl/img_block_transpose_buf.sv
// Two-bank ping-pong block buffer: collects BLK_N x BLK_N samples in raster order and
// replays each block in raster or transposed order through one registered output stage.
module img_block_transpose_buf #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned BLK_N  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  img_block_transpose_buf_if.slave  bus
);

  localparam int unsigned N2     = BLK_N * BLK_N;
  localparam int unsigned IDX_W  = $clog2(N2);
  localparam int unsigned HALF_W = $clog2(BLK_N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N2 - 1);

  logic [DATA_W-1:0] mem_q [2][N2];

  logic [1:0]        full_q, full_d;
  logic [1:0]        mode_bit_q, mode_bit_d;
  logic              wb_q, wb_d;
  logic              rb_q, rb_d;
  logic [IDX_W-1:0]  wptr_q, wptr_d;
  logic [IDX_W-1:0]  ridx_q, ridx_d;
  logic              ready_en_q;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_first_q, out_first_d;
  logic              out_last_q, out_last_d;

  logic              in_ready_c;
  logic              wr_fire_c;
  logic              rd_adv_c;
  logic [IDX_W-1:0]  rd_addr_c;
  logic [DATA_W-1:0] rd_data_c;

  assign in_ready_c = ready_en_q && !full_q[wb_q];
  assign wr_fire_c  = bus.in_valid && in_ready_c;
  assign rd_adv_c   = full_q[rb_q] && (!out_valid_q || bus.out_ready);

  // Transposed replay swaps the row and column fields of the read index.
  assign rd_addr_c = mode_bit_q[rb_q] ? {ridx_q[HALF_W-1:0], ridx_q[IDX_W-1:HALF_W]} : ridx_q;
  assign rd_data_c = mem_q[rb_q][rd_addr_c];

  always_comb begin
    full_d      = full_q;
    mode_bit_d  = mode_bit_q;
    wb_d        = wb_q;
    rb_d        = rb_q;
    wptr_d      = wptr_q;
    ridx_d      = ridx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;

    if (wr_fire_c) begin
      if (wptr_q == '0) mode_bit_d[wb_q] = bus.mode;
      if (wptr_q == LAST_IDX) begin
        wptr_d       = '0;
        full_d[wb_q] = 1'b1;
        wb_d         = ~wb_q;
      end else begin
        wptr_d = wptr_q + IDX_W'(1);
      end
    end

    // Write and read only ever touch different banks, so both updates can land together.
    if (rd_adv_c) begin
      out_valid_d = 1'b1;
      out_data_d  = rd_data_c;
      out_first_d = (ridx_q == '0);
      out_last_d  = (ridx_q == LAST_IDX);
      if (ridx_q == LAST_IDX) begin
        ridx_d       = '0;
        full_d[rb_q] = 1'b0;
        rb_d         = ~rb_q;
      end else begin
        ridx_d = ridx_q + IDX_W'(1);
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q      <= '0;
      mode_bit_q  <= '0;
      wb_q        <= 1'b0;
      rb_q        <= 1'b0;
      wptr_q      <= '0;
      ridx_q      <= '0;
      ready_en_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      full_q      <= full_d;
      mode_bit_q  <= mode_bit_d;
      wb_q        <= wb_d;
      rb_q        <= rb_d;
      wptr_q      <= wptr_d;
      ridx_q      <= ridx_d;
      ready_en_q  <= 1'b1;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
    end
  end

  // Sample storage carries no reset; contents are meaningless until a block is written.
  always_ff @(posedge clk) begin
    if (wr_fire_c) mem_q[wb_q][wptr_q] <= bus.in_data;
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_first = out_first_q;
  assign bus.out_last  = out_last_q;

endmodule
